// File: rtl/rtl_ram_dp_if.sv
// Two-port RAM request/response bundle plus clear-sequencer handshake.
// master drives requests, slave is the RAM.
interface rtl_ram_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                      ena;
  logic                      enb;
  logic [DATA_WIDTH/8-1:0]   wea;
  logic [DATA_WIDTH/8-1:0]   web;
  logic [ADDR_WIDTH-1:0]     addra;
  logic [ADDR_WIDTH-1:0]     addrb;
  logic [DATA_WIDTH-1:0]     dina;
  logic [DATA_WIDTH-1:0]     dinb;
  logic [DATA_WIDTH-1:0]     douta;
  logic [DATA_WIDTH-1:0]     doutb;
  logic                      vala;
  logic                      valb;
  logic                      clr_req;
  logic                      busy;

  modport master (
    output ena, enb, wea, web, addra, addrb, dina, dinb, clr_req,
    input  douta, doutb, vala, valb, busy
  );

  modport slave (
    input  ena, enb, wea, web, addra, addrb, dina, dinb, clr_req,
    output douta, doutb, vala, valb, busy
  );
endinterface

// File: rtl/rtl_ram_dp.sv
// Single-clock dual-port RAM, byte-lane writes, 2-edge registered latency,
// with a zero-fill clear sequencer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RESET | held while rsta_n=0; leaves on the first edge after release
// ST_CLEAR | busy=1, sweep writes zero to clr_cnt each edge
// ST_RUN   | normal operation, clr_req restarts the sweep
module rtl_ram_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clka,
  input  logic              rsta_n,
  rtl_ram_dp_if.slave       bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;

  state_t                  state, state_nxt;
  logic                    busy_c;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   clr_cnt;

  logic                    s1_ena, s1_enb;
  logic [NB-1:0]           s1_wea, s1_web;
  logic [ADDR_WIDTH-1:0]   s1_addra, s1_addrb;
  logic [DATA_WIDTH-1:0]   s1_dina, s1_dinb;

  logic [DATA_WIDTH-1:0]   douta_q, doutb_q;
  logic                    vala_q, valb_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_a, wr_b, rd_a, rd_b;
  logic [DATA_WIDTH-1:0]   old_a, old_b, rdata_a, rdata_b;
  logic [NB-1:0]           xbe_a, xbe_b;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int j = 0; j < NB; j++) begin
      if (be[j]) r[j*8 +: 8] = new_w[j*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    case (state)
      ST_RESET: state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      ST_CLEAR: begin
        busy_c = 1'b1;
        if (&clr_cnt) state_nxt = ST_RUN;
      end
      ST_RUN:   if (bus.clr_req) state_nxt = ST_CLEAR;
      default:  state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
    end
  end

  // Gate on the state this edge enters, so nothing is taken while busy will be high.
  assign accept = (state_nxt == ST_RUN);

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      s1_ena   <= 1'b0;
      s1_enb   <= 1'b0;
      s1_wea   <= '0;
      s1_web   <= '0;
      s1_addra <= '0;
      s1_addrb <= '0;
      s1_dina  <= '0;
      s1_dinb  <= '0;
    end else begin
      s1_ena   <= bus.ena & accept;
      s1_enb   <= bus.enb & accept;
      s1_wea   <= bus.wea;
      s1_web   <= bus.web;
      s1_addra <= bus.addra;
      s1_addrb <= bus.addrb;
      s1_dina  <= bus.dina;
      s1_dinb  <= bus.dinb;
    end
  end

  always_comb begin
    wr_a  = s1_ena & (|s1_wea);
    wr_b  = s1_enb & (|s1_web);
    rd_a  = s1_ena & ~(|s1_wea);
    rd_b  = s1_enb & ~(|s1_web);
    old_a = mem[s1_addra];
    old_b = mem[s1_addrb];
    xbe_a = (wr_b && (s1_addrb == s1_addra)) ? s1_web : '0;
    xbe_b = (wr_a && (s1_addra == s1_addrb)) ? s1_wea : '0;
    rdata_a = (RDW_MODE != 0) ? merge(old_a, s1_dinb, xbe_a) : old_a;
    rdata_b = (RDW_MODE != 0) ? merge(old_b, s1_dina, xbe_b) : old_b;
  end

  // B lanes first, A lanes after: on a shared lane A's assignment lands last.
  always_ff @(posedge clka) begin
    for (int j = 0; j < NB; j++) begin
      if (wr_b && s1_web[j]) mem[s1_addrb][j*8 +: 8] <= s1_dinb[j*8 +: 8];
    end
    for (int j = 0; j < NB; j++) begin
      if (wr_a && s1_wea[j]) mem[s1_addra][j*8 +: 8] <= s1_dina[j*8 +: 8];
    end
    if (state == ST_CLEAR) mem[clr_cnt] <= '0;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      douta_q <= '0;
      doutb_q <= '0;
      vala_q  <= 1'b0;
      valb_q  <= 1'b0;
    end else begin
      vala_q <= rd_a;
      valb_q <= rd_b;
      if (rd_a) douta_q <= rdata_a;
      if (rd_b) doutb_q <= rdata_b;
    end
  end

  assign bus.douta = douta_q;
  assign bus.doutb = doutb_q;
  assign bus.vala  = vala_q;
  assign bus.valb  = valb_q;
  assign bus.busy  = busy_c;

endmodule

// File: tb/tb_rtl_ram_dp.sv
// Directed bench: one READ_FIRST and one WRITE_FIRST instance on identical stimulus.
module tb_rtl_ram_dp;
  logic clka = 1'b0;
  logic rsta_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clka = ~clka;

  rtl_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();
  rtl_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();

  assign bus1.ena     = bus0.ena;
  assign bus1.enb     = bus0.enb;
  assign bus1.wea     = bus0.wea;
  assign bus1.web     = bus0.web;
  assign bus1.addra   = bus0.addra;
  assign bus1.addrb   = bus0.addrb;
  assign bus1.dina    = bus0.dina;
  assign bus1.dinb    = bus0.dinb;
  assign bus1.clr_req = bus0.clr_req;

  rtl_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clka(clka), .rsta_n(rsta_n), .bus(bus0));
  rtl_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clka(clka), .rsta_n(rsta_n), .bus(bus1));

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_a(input logic en, input logic [3:0] we, input logic [3:0] addr,
                       input logic [31:0] din);
    bus0.ena = en; bus0.wea = we; bus0.addra = addr; bus0.dina = din;
  endtask

  task automatic set_b(input logic en, input logic [3:0] we, input logic [3:0] addr,
                       input logic [31:0] din);
    bus0.enb = en; bus0.web = we; bus0.addrb = addr; bus0.dinb = din;
  endtask

  initial begin
    set_a(1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b0, 4'h0, 4'd0, 32'h0);
    bus0.clr_req = 1'b0;
    tick(); tick(); tick();
    chk("rst_douta", bus0.douta, 32'h0);
    chk("rst_vala",  {31'b0, bus0.vala}, 32'h0);
    chk("rst_busy",  {31'b0, bus0.busy}, 32'h0);

    // auto-clear after reset, port A hammering address 5 throughout
    set_a(1'b1, 4'h0, 4'd5, 32'h0);
    rsta_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk($sformatf("auto_busy_k%0d", k), {31'b0, bus0.busy}, {31'b0, (k <= 16)});
      chk($sformatf("auto_vala_k%0d", k), {31'b0, bus0.vala}, {31'b0, (k == 18)});
    end
    chk("auto_first_read", bus0.douta, 32'h0);
    set_a(1'b0, 4'h0, 4'd0, 32'h0);
    tick();

    // byte lanes
    set_a(1'b1, 4'hF, 4'd3, 32'hDEADBEEF);
    tick();
    set_a(1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b1, 4'b0101, 4'd3, 32'h11223344);
    tick();
    set_b(1'b0, 4'h0, 4'd0, 32'h0);
    set_a(1'b1, 4'h0, 4'd3, 32'h0);
    tick();
    set_a(1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("lane_douta", bus0.douta, 32'hDE22BE44);
    chk("lane_vala",  {31'b0, bus0.vala}, 32'h1);
    tick();
    chk("lane_vala_pulse", {31'b0, bus0.vala}, 32'h0);

    // same-cycle collision, A wins
    set_a(1'b1, 4'hF, 4'd7, 32'hAAAAAAAA);
    set_b(1'b1, 4'hF, 4'd7, 32'hBBBBBBBB);
    tick();
    set_a(1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b1, 4'h0, 4'd7, 32'h0);
    tick();
    set_b(1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("coll_doutb", bus0.doutb, 32'hAAAAAAAA);
    chk("coll_valb",  {31'b0, bus0.valb}, 32'h1);
    chk("coll_vala",  {31'b0, bus0.vala}, 32'h0);

    // read-during-write across ports
    set_a(1'b1, 4'hF, 4'd9, 32'h1);
    tick();
    set_a(1'b1, 4'hF, 4'd9, 32'h2);
    set_b(1'b1, 4'h0, 4'd9, 32'h0);
    tick();
    set_a(1'b0, 4'h0, 4'd0, 32'h0);
    set_b(1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("rdw_read_first",  bus0.doutb, 32'h1);
    chk("rdw_write_first", bus1.doutb, 32'h2);
    chk("rdw_valb",        {31'b0, bus0.valb}, 32'h1);
    set_b(1'b1, 4'h0, 4'd9, 32'h0);
    tick();
    set_b(1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("rdw_later_rf", bus0.doutb, 32'h2);
    chk("rdw_later_wf", bus1.doutb, 32'h2);

    // pipelined reads of 0..7
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 4'hF, 4'(i), 32'(i));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_a(1'b1, 4'h0, 4'(i), 32'h0);
      else       set_a(1'b0, 4'h0, 4'd0, 32'h0);
      tick();
      chk($sformatf("pipe_vala_%0d", i), {31'b0, bus0.vala}, {31'b0, (i >= 1 && i <= 8)});
      if (i >= 1 && i <= 8) chk($sformatf("pipe_douta_%0d", i), bus0.douta, 32'(i - 1));
    end
    chk("pipe_hold", bus0.douta, 32'h7);

    // clr_req, then reset at sweep address 6
    bus0.clr_req = 1'b1;
    tick();
    bus0.clr_req = 1'b0;
    chk("clr_busy", {31'b0, bus0.busy}, 32'h1);
    for (int k = 0; k < 6; k++) tick();
    rsta_n = 1'b0;
    #1;
    chk("mid_busy",  {31'b0, bus0.busy}, 32'h0);
    chk("mid_douta", bus0.douta, 32'h0);
    chk("mid_doutb", bus0.doutb, 32'h0);
    chk("mid_vala",  {31'b0, bus0.vala}, 32'h0);
    tick(); tick();
    rsta_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("resweep_busy_k%0d", k), {31'b0, bus0.busy}, {31'b0, (k <= 16)});
      bus0.clr_req = (k == 5);
    end
    bus0.clr_req = 1'b0;
    set_a(1'b1, 4'h0, 4'd3, 32'h0);
    set_b(1'b1, 4'h0, 4'd9, 32'h0);
    tick();
    set_a(1'b1, 4'h0, 4'd7, 32'h0);
    set_b(1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("swept_a3", bus0.douta, 32'h0);
    chk("swept_b9", bus0.doutb, 32'h0);
    chk("swept_b9_wf", bus1.doutb, 32'h0);
    set_a(1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("swept_a7", bus0.douta, 32'h0);
    chk("swept_vala", {31'b0, bus0.vala}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rtl_ram_dp.md
# rtl_ram_dp

Parametrised single-clock dual-port RAM that supersedes the single-port registered RAM in the CPU datapath. It has two independent read/write ports with byte-lane write enables and the same two-cycle registered-input and registered-output latency. It adds a per-port read-valid flag, a configurable read-during-write mode, and a hardware clear sequencer that zero-fills the array after reset or on request. Instruction fetch uses port A and load/store uses port B.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address width; DEPTH = 2**ADDR_WIDTH words.
- RDW_MODE, 0, read-during-write behaviour: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).
- CLEAR_ON_RESET, 1, 1 = run a zero-fill sweep automatically after reset deasserts.
- Ports (clock and reset first):
  - clka  in  1  sole clock, rising edge.
  - rsta_n  in  1  asynchronous active-low reset.
  - ena / enb  in  1  port request enable.
  - wea / web  in  DATA_WIDTH/8  byte-lane write enables; all-zero = read.
  - addra / addrb  in  ADDR_WIDTH  word address.
  - dina / dinb  in  DATA_WIDTH  write data.
  - douta / doutb  out  DATA_WIDTH  registered read data.
  - vala / valb  out  1  one-cycle pulse: dout carries data of a read request.
  - clr_req  in  1  single-cycle pulse; starts a zero-fill sweep.
  - busy  out  1  high while a sweep runs.

## Operation
- Pipeline per port:
  - S1 registers en, we, addr and din at every edge.
  - S2 performs the array access from the S1 registers.
  - S2 updates dout only for reads (en=1, we=0); otherwise dout holds its value.
- Writes update only the byte lanes whose we bit is 1; other lanes keep their contents.
- A write request produces no val pulse. A read request produces exactly one val pulse.
- Same-port read-during-write does not occur, because we selects read or write.
- Cross-port, same address, same cycle:
  - A and B both write: byte lanes written by both ports take port A data; lanes written by one port only take that port's data.
  - One port writes, the other reads: the reader gets the old word if RDW_MODE=0. If RDW_MODE=1 it gets the merged new word (byte-enable applied to the old word).
- Clear sequencer FSM, states RESET, CLEAR, RUN:
  - RESET: held while rsta_n=0. On release, go to CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR: busy=1. The internal counter writes zero to address 0..DEPTH-1, one word per cycle. After address DEPTH-1 is written, go to RUN; the counter wraps to 0.
  - RUN: busy=0. clr_req=1 returns the FSM to CLEAR with the counter at 0.
  - clr_req while in CLEAR is ignored; the sweep does not restart.
- Request handling during CLEAR:
  - ena/enb sampled while busy=1 are dropped: S1 en registers are forced to 0, so no write and no val.
  - A request already in S1 when CLEAR is entered completes normally, ahead of the sweep's first write.
- Reset (asynchronous, any time, including mid-sweep):
  - Clears all S1 registers, douta/doutb, vala/valb, busy and the sweep counter to 0.
  - Array contents are not reset; they are undefined until a sweep completes.

## Timing
- Read latency is 2 edges. A request sampled at edge E0 produces dout and val at edge E1 (E0+1), visible after E1.
- A write sampled at E0 commits at E1. A read sampled at E1 or later observes it.
- Back-to-back requests are accepted every cycle on both ports (throughput 1/port/cycle).
- A clr_req pulse sampled at edge C sets busy at C. The sweep writes address k at edge C+1+k.
- busy falls at C+DEPTH, with the last write at that edge. The first request accepted is one sampled at C+DEPTH or later, while busy=0.
- Auto-clear after reset: same timing, with C being the first edge after rsta_n rises.
- Output values after reset: douta=0, doutb=0, vala=0, valb=0, busy=0. busy goes to 1 at the first edge after release when CLEAR_ON_RESET=1.

## Test plan
- CLEAR_ON_RESET=1, ADDR_WIDTH=4:
  - Release reset, hold ena=1 and read address 5 every cycle.
  - Required: busy=1 for exactly 16 cycles; vala stays 0 throughout.
  - The first accepted read returns 0x00000000 with vala 2 edges later.
- Byte lanes:
  - Write 0xDEADBEEF to A:3 with wea=4'b1111, then write 0x11223344 to B:3 with web=4'b0101.
  - Read A:3 returns 0xDE22BE44.
- Collision:
  - Same cycle: A writes 0xAAAAAAAA to address 7 (wea=4'b1111) and B writes 0xBBBBBBBB to address 7 (web=4'b1111).
  - A subsequent read returns 0xAAAAAAAA.
- Read-during-write:
  - Address 9 holds 0x1. Same cycle: A writes 0x2 (wea=4'b1111) and B reads 9.
  - doutb=0x1 with RDW_MODE=0 and 0x2 with RDW_MODE=1. A later read returns 0x2 in both modes.
- Pipelined reads:
  - Address i holds i for i=0..7. Read A:0..7 on consecutive cycles.
  - vala is high for 8 consecutive cycles starting 2 edges after the first request; douta steps 0..7.
- Reset mid-sweep:
  - Pulse clr_req, then drop rsta_n at sweep address 6.
  - Outputs and busy read 0 immediately, without waiting for an edge.
  - On release the sweep restarts at address 0 and runs the full 16 cycles.
